// File: rtl/piece_bag_generator.sv
// Piece dealer: Galois LFSR candidates, optional 7-bag rule, FIFO preview queue
// consumed through a valid/take handshake. Every output comes straight from a register.
module piece_bag_generator #(
    parameter int                PIECE_TYPES   = 7,
    parameter int                PIECE_W       = 3,
    parameter int                PREVIEW_DEPTH = 3,
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter bit                BAG_MODE      = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               take,
    output logic                               valid,
    output logic [PIECE_W-1:0]                 piece,
    output logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview,
    output logic [$clog2(PREVIEW_DEPTH+1)-1:0] fill_level,
    output logic [PIECE_TYPES-1:0]             bag_mask
);

    localparam int FW = $clog2(PREVIEW_DEPTH + 1);
    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0]      lfsr_reg, lfsr_next;
    logic [PIECE_W-1:0]     slot_reg  [PREVIEW_DEPTH];
    logic [PIECE_W-1:0]     slot_next [PREVIEW_DEPTH];
    logic [FW-1:0]          fill_reg, fill_next;
    logic [PIECE_TYPES-1:0] mask_reg, mask_next;
    logic [PIECE_TYPES-1:0] cand_hot, mask_set;
    logic [PIECE_W-1:0]     cand;
    logic [FW-1:0]          push_idx;
    logic                   in_range, seen, pop, slot_free, accept;

    assign lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
    assign cand      = lfsr_reg[PIECE_W-1:0];

    // One-hot of the candidate over the legal codes; stays zero for out-of-range codes.
    generate
        for (genvar gi = 0; gi < PIECE_TYPES; gi++) begin : g_hot
            assign cand_hot[gi] = (cand == PIECE_W'(gi));
        end
    endgenerate

    assign in_range  = ({1'b0, cand} < (PIECE_W + 1)'(PIECE_TYPES));
    assign seen      = BAG_MODE ? |(cand_hot & mask_reg) : 1'b0;
    assign pop       = take & (fill_reg != '0);
    assign slot_free = (fill_reg < FW'(PREVIEW_DEPTH)) | pop;
    assign accept    = in_range & ~seen & slot_free;
    // Tail position after any pop has shifted the queue down by one.
    assign push_idx  = fill_reg - FW'(pop);
    assign fill_next = fill_reg + FW'(accept) - FW'(pop);

    generate
        for (genvar gi = 0; gi < PREVIEW_DEPTH; gi++) begin : g_slot
            logic [PIECE_W-1:0] shifted;
            if (gi == PREVIEW_DEPTH - 1) begin : g_top
                assign shifted = pop ? '0 : slot_reg[gi];
            end else begin : g_mid
                assign shifted = pop ? slot_reg[gi+1] : slot_reg[gi];
            end
            assign slot_next[gi] = (accept && (push_idx == FW'(gi))) ? cand : shifted;
            assign preview[gi*PIECE_W +: PIECE_W] = slot_reg[gi];
        end
    endgenerate

    assign mask_set = mask_reg | cand_hot;

    always_comb begin
        mask_next = mask_reg;
        if (!BAG_MODE) begin
            mask_next = '0;
        end else if (accept) begin
            // Completing the bag opens a fresh one on the same edge.
            mask_next = (&mask_set) ? '0 : mask_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= SEED_EFF;
            fill_reg <= '0;
            mask_reg <= '0;
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            lfsr_reg <= lfsr_next;
            fill_reg <= fill_next;
            mask_reg <= mask_next;
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    assign valid      = (fill_reg != '0);
    assign piece      = slot_reg[0];
    assign fill_level = fill_reg;
    assign bag_mask   = mask_reg;

endmodule

// File: tb/tb_piece_bag_generator.sv
// Directed bench for piece_bag_generator: hand-traced LFSR deals, bag permutation,
// take/push overlap, reset behaviour, and a uniform-mode range sweep.
module tb_piece_bag_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       take = 1'b0;
    logic       take2 = 1'b0;

    logic       valid, valid2;
    logic [2:0] piece, piece2;
    logic [8:0] preview, preview2;
    logic [1:0] fill_level, fill_level2;
    logic [6:0] bag_mask;
    logic [4:0] bag_mask2;

    int n_checks = 0;
    int n_fail   = 0;

    piece_bag_generator dut (
        .clk        (clk),
        .reset      (reset),
        .take       (take),
        .valid      (valid),
        .piece      (piece),
        .preview    (preview),
        .fill_level (fill_level),
        .bag_mask   (bag_mask)
    );

    piece_bag_generator #(
        .PIECE_TYPES (5),
        .BAG_MODE    (1'b0)
    ) dut_uni (
        .clk        (clk),
        .reset      (reset),
        .take       (take2),
        .valid      (valid2),
        .piece      (piece2),
        .preview    (preview2),
        .fill_level (fill_level2),
        .bag_mask   (bag_mask2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [31:0] v, input logic [31:0] p,
                               input logic [31:0] pv, input logic [31:0] f, input logic [31:0] m);
        check({tag, "_valid"},   32'(valid),      v);
        check({tag, "_piece"},   32'(piece),      p);
        check({tag, "_preview"}, 32'(preview),    pv);
        check({tag, "_fill"},    32'(fill_level), f);
        check({tag, "_mask"},    32'(bag_mask),   m);
        $display("%s: valid=%0d piece=%0d preview=0x%03h fill=%0d mask=0x%02h",
                 tag, valid, piece, preview, fill_level, bag_mask);
    endtask

    initial begin
        int         acc, got, grp_n, cyc, d, cnt, bad, mbad;
        logic       pop;
        logic [1:0] fb;
        logic [2:0] pc;
        logic [7:0] seen;

        // Power-on reset, then the hand-traced deal from seed 0xACE1:
        // candidates 1, 0, 0(repeat), 4, 6, ...
        repeat (3) step();
        check_state("rst", 0, 0, 0, 0, 0);
        check("rst_uni_fill", 32'(fill_level2), 0);
        reset = 1'b0;
        step();
        check_state("e1", 1, 1, 9'h001, 1, 7'h02);
        step();
        check_state("e2", 1, 1, 9'h001, 2, 7'h03);
        step();
        check_state("e3_reject", 1, 1, 9'h001, 2, 7'h03);
        check("e3_uni_fill", 32'(fill_level2), 3);
        check("e3_uni_preview", 32'(preview2), 32'h001);
        check("e3_uni_mask", 32'(bag_mask2), 0);
        step();
        check_state("e4_full", 1, 1, 9'h101, 3, 7'h13);
        check("e4_popcount", 32'($countones(bag_mask)), 3);
        take = 1'b1;
        step();
        take = 1'b0;
        check_state("e5_take_push", 1, 0, 9'h1A0, 3, 7'h53);
        repeat (10) step();
        check_state("hold_full", 1, 0, 9'h1A0, 3, 7'h53);

        // Reset with two pieces queued, then take while empty, then replay.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check("mid_fill", 32'(fill_level), 2);
        reset = 1'b1;
        step();
        check_state("mid_rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        take  = 1'b1;
        step();
        take  = 1'b0;
        check_state("take_empty", 1, 1, 9'h001, 1, 7'h02);
        step();
        check_state("replay_e2", 1, 1, 9'h001, 2, 7'h03);
        step();
        step();
        check_state("replay_e4", 1, 1, 9'h101, 3, 7'h13);

        // Bag mode drain: take whenever valid, 21 pieces in three permutations.
        reset = 1'b1;
        step();
        reset = 1'b0;
        acc = 0; got = 0; grp_n = 0; cyc = 0; seen = '0;
        while (got < 21 && cyc < 5000) begin
            pop  = valid;
            take = valid;
            fb   = fill_level;
            pc   = piece;
            step();
            cyc++;
            d = int'(fill_level) - int'(fb) + int'(pop);
            if (d == 1) begin
                acc++;
                if (acc % 7 == 0)
                    check("bag_clear", 32'(bag_mask), 0);
                else
                    check("bag_popcount", 32'($countones(bag_mask)), 32'(acc % 7));
            end
            if (pop) begin
                seen = seen | (8'd1 << pc);
                grp_n++;
                got++;
                if (grp_n == 7) begin
                    check("bag_perm", 32'(seen), 32'h7F);
                    $display("bag %0d complete: seen=0x%02h after %0d cycles", got / 7, seen, cyc);
                    seen  = '0;
                    grp_n = 0;
                end
            end
        end
        take = 1'b0;
        check("bag_count", 32'(got), 21);

        // Uniform mode, 5 types: long sweep for range and a permanently clear mask.
        take2 = 1'b1;
        cnt = 0; bad = 0; mbad = 0; cyc = 0;
        while (cnt < 10000 && cyc < 40000) begin
            if (valid2) begin
                cnt++;
                if (piece2 >= 3'd5) bad++;
            end
            if (bag_mask2 != '0) mbad++;
            step();
            cyc++;
        end
        take2 = 1'b0;
        check("uni_count", 32'(cnt), 10000);
        check("uni_range", 32'(bad), 0);
        check("uni_mask", 32'(mbad), 0);
        $display("uniform sweep: %0d pieces in %0d cycles", cnt, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
